// File: rtl/chunked_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
package chunked_addsub_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Number of CHUNK-bit slices in a WIDTH-bit operand.
   function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   // Chunk-index register width; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned nch);
      return (nch <= 32'd1) ? 32'd1 : unsigned'($clog2(nch));
   endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Request/response bundle between a requester and chunked_addsub.
interface chunked_addsub_if #(
   parameter int unsigned WIDTH = 16
) ();

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;
   logic             v;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, s, c, v
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, s, c, v
   );

endinterface

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells.
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   // Ripple the carry LSB to MSB; tap the carry entering the top cell for overflow.
   always_comb begin : p_ripple
      logic carry;
      carry    = ci;
      s        = '0;
      c_msb_in = 1'b0;
      for (int i = 0; i < int'(CHUNK); i++) begin
         if (i == int'(CHUNK) - 1) c_msb_in = carry;
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry held between chunks.
module chunked_addsub
   import chunked_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input logic             CLK,
   input logic             RST,
   chunked_addsub_if.slave bus
);

   localparam int unsigned NCh  = num_chunks(WIDTH, CHUNK);
   localparam int unsigned IdxW = idx_width(NCh);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NCh - 1);

   if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_param_check
      $error("chunked_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d;
   logic [WIDTH-1:0]  op_b_q, op_b_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;
   logic [IdxW-1:0]   k_q, k_d;
   logic [WIDTH-1:0]  s_q, s_d;
   logic              c_q, c_d;
   logic              v_q, v_d;

   logic [CHUNK-1:0]  chunk_s;
   logic              chunk_co;
   logic              chunk_cmsb;
   logic [WIDTH-1:0]  sum_next;

   // Operands are shifted right each step, so the active slice always sits at bit 0.
   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a        (op_a_q[CHUNK-1:0]),
      .b        (op_b_q[CHUNK-1:0]),
      .ci       (carry_q),
      .s        (chunk_s),
      .co       (chunk_co),
      .c_msb_in (chunk_cmsb)
   );

   // New slice enters at the top; after NCh steps the register holds the full result.
   assign sum_next = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      k_d     = k_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               // Subtract as A + ~B + ~borrow_in.
               op_a_d  = bus.a;
               op_b_d  = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? ~bus.cin : bus.cin;
               k_d     = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            op_a_d  = op_a_q >> CHUNK;
            op_b_d  = op_b_q >> CHUNK;
            sum_d   = sum_next;
            carry_d = chunk_co;
            k_d     = k_q + 1'b1;
            if (k_q == LastIdx) begin
               s_d     = sum_next;
               c_d     = chunk_co;
               v_d     = chunk_co ^ chunk_cmsb;
               k_d     = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         s_q     <= s_d;
         c_q     <= c_d;
         v_q     <= v_d;
      end
   end

   assign bus.busy = (state_q == StRun);
   assign bus.done = (state_q == StDone);
   assign bus.s    = s_q;
   assign bus.c    = c_q;
   assign bus.v    = v_q;

endmodule
